// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator operand-stack sequencer:
// command codes, error codes, FSM states and default sizing.
package rpn_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [2:0] {
    CMD_PUSH = 3'd0,
    CMD_POP  = 3'd1,
    CMD_ADD  = 3'd2,
    CMD_SUB  = 3'd3,
    CMD_MUL  = 3'd4,
    CMD_NEG  = 3'd5,
    CMD_CLR  = 3'd6,
    CMD_NOP  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_FULL      = 2'd2,
    ERR_ARITH_OVF = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/rpn_stack_controller_if.sv
// Command/status bundle between the push-button front end (master) and
// the stack controller (slave).
interface rpn_stack_controller_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic                    cmd_valid;
  logic [2:0]              cmd;
  logic signed [WIDTH-1:0] operand;
  logic                    busy;
  logic signed [WIDTH-1:0] top;
  logic                    top_valid;
  logic [DW-1:0]           depth;
  logic [1:0]              err_code;
  logic                    cmd_dropped;

  modport master (
    output cmd_valid, cmd, operand,
    input  busy, top, top_valid, depth, err_code, cmd_dropped
  );

  modport slave (
    input  cmd_valid, cmd, operand,
    output busy, top, top_valid, depth, err_code, cmd_dropped
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational arithmetic for the stack controller. Results are formed at
// full precision, truncated to WIDTH bits, and flagged when the full value
// does not fit the WIDTH-bit two's-complement range.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  cmd_e                    op,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf
);

  logic signed [WIDTH:0]     a_w;
  logic signed [WIDTH:0]     b_w;
  logic signed [WIDTH:0]     sum;
  logic signed [WIDTH:0]     diff;
  logic signed [WIDTH:0]     neg;
  logic signed [2*WIDTH-1:0] a_x;
  logic signed [2*WIDTH-1:0] b_x;
  logic signed [2*WIDTH-1:0] prod;

  // A WIDTH+1 bit value fits WIDTH bits when its top two bits agree.
  function automatic logic narrow_ovf(input logic signed [WIDTH:0] v);
    return v[WIDTH] != v[WIDTH-1];
  endfunction

  // A product fits WIDTH bits when bits [2W-1:W-1] are all copies of the sign.
  function automatic logic mul_ovf(input logic signed [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  assign a_w  = {a[WIDTH-1], a};
  assign b_w  = {b[WIDTH-1], b};
  assign sum  = b_w + a_w;
  assign diff = b_w - a_w;
  assign neg  = -a_w;
  assign a_x  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_x  = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod = b_x * a_x;

  // Select the operation result and its overflow flag.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      CMD_ADD: begin
        result = sum[WIDTH-1:0];
        ovf    = narrow_ovf(sum);
      end
      CMD_SUB: begin
        result = diff[WIDTH-1:0];
        ovf    = narrow_ovf(diff);
      end
      CMD_MUL: begin
        result = prod[WIDTH-1:0];
        ovf    = mul_ovf(prod);
      end
      CMD_NEG: begin
        result = neg[WIDTH-1:0];
        ovf    = narrow_ovf(neg);
      end
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rpn_stack_controller.sv
// Operand-stack sequencer for the RPN calculator. Single-cycle commands act
// on the accepting edge; binary operations walk RD_A -> RD_B -> EXEC -> WB,
// popping both operands before pushing the result.
module rpn_stack_controller
  import rpn_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rpn_stack_controller_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  state_e                  state_q, state_d;
  logic [DW-1:0]           depth_q, depth_d;
  err_e                    err_q, err_d;
  logic                    dropped_q;

  logic signed [WIDTH-1:0] stack_q [DEPTH];
  logic signed [WIDTH-1:0] a_q, b_q, r_q;
  cmd_e                    op_q;

  logic [AW-1:0]           top_idx;
  logic signed [WIDTH-1:0] top_val;
  logic                    accept;

  logic                    wr_en;
  logic [AW-1:0]           wr_idx;
  logic signed [WIDTH-1:0] wr_data;

  cmd_e                    alu_op;
  logic signed [WIDTH-1:0] alu_a;
  logic signed [WIDTH-1:0] alu_res;
  logic                    alu_ovf;

  assign top_idx = AW'(depth_q) - AW'(1);
  assign top_val = stack_q[top_idx];
  assign accept  = (state_q == ST_IDLE) && bus.cmd_valid;

  // NEG is the only ALU use while idle; otherwise the latched binary op runs.
  assign alu_op = (state_q == ST_IDLE) ? CMD_NEG : op_q;
  assign alu_a  = (state_q == ST_IDLE) ? top_val : a_q;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (b_q),
    .op     (alu_op),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  // Next-state, depth, error and stack-write decode.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = AW'(depth_q);
    wr_data = bus.operand;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          err_d = ERR_NONE;
          case (bus.cmd)
            CMD_PUSH: begin
              if (depth_q == DW'(DEPTH)) begin
                err_d = ERR_FULL;
              end else begin
                wr_en   = 1'b1;
                depth_d = depth_q + DW'(1);
              end
            end
            CMD_POP: begin
              if (depth_q == '0) err_d = ERR_UNDERFLOW;
              else               depth_d = depth_q - DW'(1);
            end
            CMD_ADD, CMD_SUB, CMD_MUL: begin
              if (depth_q < DW'(2)) err_d = ERR_UNDERFLOW;
              else                  state_d = ST_RD_A;
            end
            CMD_NEG: begin
              if (depth_q == '0) begin
                err_d = ERR_UNDERFLOW;
              end else begin
                wr_en   = 1'b1;
                wr_idx  = top_idx;
                wr_data = alu_res;
                if (alu_ovf) err_d = ERR_ARITH_OVF;
              end
            end
            CMD_CLR: depth_d = '0;
            default: ;
          endcase
        end
      end
      ST_RD_A: begin
        depth_d = depth_q - DW'(1);
        state_d = ST_RD_B;
      end
      ST_RD_B: begin
        depth_d = depth_q - DW'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (alu_ovf) err_d = ERR_ARITH_OVF;
        state_d = ST_WB;
      end
      ST_WB: begin
        wr_en   = 1'b1;
        wr_data = r_q;
        depth_d = depth_q + DW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      depth_q   <= '0;
      err_q     <= ERR_NONE;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
      dropped_q <= bus.cmd_valid && (state_q != ST_IDLE);
    end
  end

  // Stack storage and operand/result latches; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) stack_q[wr_idx] <= wr_data;
    if (accept) op_q <= cmd_e'(bus.cmd);
    if (state_q == ST_RD_A) a_q <= top_val;
    if (state_q == ST_RD_B) b_q <= top_val;
    if (state_q == ST_EXEC) r_q <= alu_res;
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.top_valid   = (depth_q != '0);
  assign bus.top         = bus.top_valid ? top_val : '0;
  assign bus.depth       = depth_q;
  assign bus.err_code    = err_q;
  assign bus.cmd_dropped = dropped_q;

endmodule
